// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipeline-stage registers of the
//            five-stage datapath: stage-register state encoding, default
//            control-field widths per pipeline boundary and the bit layout
//            of the WB/M/EX control sub-fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // Stage-register occupancy state
   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,   // no entry held
      PS_HALF  = 2'd1,   // main register valid
      PS_FULL  = 2'd2    // main and skid registers valid
   } ps_state_t;

   // Default control-field width per boundary. IF/ID carries no control
   // bits; its instance has to be built without a control field.
   localparam int c_ctrl_w_ifid  = 0;
   localparam int c_ctrl_w_idex  = 10;
   localparam int c_ctrl_w_exmem = 5;
   localparam int c_ctrl_w_memwb = 2;

   // Control-field layout at ID/EX: {WB[1:0], M[2:0], EX[4:0]}.
   // The EX bits sit lowest so later boundaries keep the upper slice
   // ({WB,M} at EX/MEM, {WB} at MEM/WB).
   localparam int c_ex_lsb = 0;
   localparam int c_ex_w   = 5;
   localparam int c_m_lsb  = 5;
   localparam int c_m_w    = 3;
   localparam int c_wb_lsb = 8;
   localparam int c_wb_w   = 2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Purpose  : One {valid, ctrl, data} holding register of a pipeline stage.
//            Clear drops validity and zeroes the control field (and the
//            payload when CLR_DATA=1); clear wins over load.
// Ports    : clk, rst (async, active-low)
//            i_load, i_clr          - update strobes
//            i_valid/i_ctrl/i_data  - value loaded on i_load
//            o_valid/o_ctrl/o_data  - held value
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry #(
   parameter int DATA_W   = 64,
   parameter int CTRL_W   = 10,
   parameter bit CLR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_clr,
   input  logic              i_valid,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         if (CLR_DATA) begin
            r_data <= '0;
         end
      end else if (i_load) begin
         r_valid <= i_valid;
         r_ctrl  <= i_ctrl;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_hs
// Purpose  : Pipeline-stage register with valid/ready handshake and a
//            two-entry skid buffer (main M drives the outputs, skid S
//            catches the beat accepted while the consumer stalls). in_ready
//            is a flop, so no combinational path runs from out_ready to
//            in_ready. flush kills everything held and incoming.
// Ports    : clk, rst (async, active-low), flush
//            in_valid/in_ready/in_ctrl/in_data     - upstream side
//            out_valid/out_ready/out_ctrl/out_data - downstream side
//            occupancy                              - entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int CTRL_W     = c_ctrl_w_idex,
   parameter bit FLUSH_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   ps_state_t         r_state;
   ps_state_t         w_state_nxt;
   logic              r_in_ready;

   logic              w_xfer_in;
   logic              w_xfer_out;

   logic              w_m_load;
   logic              w_m_clr;
   logic [CTRL_W-1:0] w_m_ctrl_d;
   logic [DATA_W-1:0] w_m_data_d;
   logic              w_s_load;
   logic              w_s_clr;

   logic              w_m_valid;
   logic [CTRL_W-1:0] w_m_ctrl;
   logic [DATA_W-1:0] w_m_data;
   logic              w_s_valid;
   logic [CTRL_W-1:0] w_s_ctrl;
   logic [DATA_W-1:0] w_s_data;

   assign w_xfer_in  = in_valid & r_in_ready;
   assign w_xfer_out = w_m_valid & out_ready;

   // Next-state and register-update decode. flush overrides every
   // transfer; a beat accepted on a flush cycle is simply never stored.
   always_comb begin
      w_state_nxt = r_state;
      w_m_load    = 1'b0;
      w_m_clr     = 1'b0;
      w_m_ctrl_d  = in_ctrl;
      w_m_data_d  = in_data;
      w_s_load    = 1'b0;
      w_s_clr     = 1'b0;

      if (flush) begin
         w_state_nxt = PS_EMPTY;
         w_m_clr     = 1'b1;
         w_s_clr     = 1'b1;
      end else begin
         case (r_state)
            PS_EMPTY: begin
               if (w_xfer_in) begin
                  w_m_load    = 1'b1;
                  w_state_nxt = PS_HALF;
               end
            end
            PS_HALF: begin
               if (w_xfer_in && w_xfer_out) begin
                  w_m_load = 1'b1;
               end else if (w_xfer_in) begin
                  // consumer stalled: park the new beat behind M
                  w_s_load    = 1'b1;
                  w_state_nxt = PS_FULL;
               end else if (w_xfer_out) begin
                  w_m_clr     = 1'b1;
                  w_state_nxt = PS_EMPTY;
               end
            end
            PS_FULL: begin
               // in_ready is low here, so only the drain can happen
               if (w_xfer_out) begin
                  w_m_load    = 1'b1;
                  w_m_ctrl_d  = w_s_ctrl;
                  w_m_data_d  = w_s_data;
                  w_s_clr     = 1'b1;
                  w_state_nxt = PS_HALF;
               end
            end
            default: begin
               w_state_nxt = PS_EMPTY;
               w_m_clr     = 1'b1;
               w_s_clr     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= PS_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != PS_FULL);
      end
   end

   pipe_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CLR_DATA (FLUSH_DATA)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_m_load),
      .i_clr   (w_m_clr),
      .i_valid (1'b1),
      .i_ctrl  (w_m_ctrl_d),
      .i_data  (w_m_data_d),
      .o_valid (w_m_valid),
      .o_ctrl  (w_m_ctrl),
      .o_data  (w_m_data)
   );

   pipe_entry #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CLR_DATA (FLUSH_DATA)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_s_load),
      .i_clr   (w_s_clr),
      .i_valid (1'b1),
      .i_ctrl  (in_ctrl),
      .i_data  (in_data),
      .o_valid (w_s_valid),
      .o_ctrl  (w_s_ctrl),
      .o_data  (w_s_data)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = w_m_valid;
   // Never expose stale write enables from an empty head.
   assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
   assign out_data  = w_m_data;
   // S is only ever valid behind a valid M, so this counts 0..2.
   assign occupancy = {w_m_valid & w_s_valid, w_m_valid ^ w_s_valid};

endmodule : pipe_stage_hs
`default_nettype wire

// File: tb/tb_pipe_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_hs
// Purpose  : Self-checking bench for pipe_stage_hs (default parameters).
//            Accepted beats go into a scoreboard queue; beats leaving the
//            stage are popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_hs;

   localparam int DW = 64;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   logic [CW+DW-1:0] sb[$];
   int               n_err = 0;
   int               n_checks = 0;

   pipe_stage_hs #(
      .DATA_W     (DW),
      .CTRL_W     (CW),
      .FLUSH_DATA (1'b0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven: check the
   // invariants and the handshake, update the scoreboard, then advance
   // one rising edge and return at the next falling edge.
   task automatic step();
      logic [CW+DW-1:0] exp_beat;
      chk("ready_vs_occ", in_ready, (occupancy != 2'd2));
      if (!out_valid) chk("ctrl_idle", out_ctrl, 0);
      if (out_valid && out_ready) begin
         chk("sb_nonempty", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_beat = sb.pop_front();
            chk("out_beat", {out_ctrl, out_data}, exp_beat);
         end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int n_in;
      int cyc;

      // ---------------- reset ----------------
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occ", occupancy, 0);
      rst = 1'b1;

      // ---------------- streaming 1..8 ----------------
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         in_ctrl  = CW'(i);
         chk("stream_ready", in_ready, 1);
         if (i > 1) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_lat", out_data, i - 1);
         end
         step();
      end
      in_valid = 1'b0;
      chk("stream_last", out_data, 8);
      step();
      chk("stream_drained", occupancy, 0);

      // ---------------- skid fill and release ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA; in_ctrl = 10'h0A;
      step();
      in_data   = 64'hB; in_ctrl = 10'h0B;
      step();
      in_data   = 64'hC; in_ctrl = 10'h0C;
      chk("skid_occ", occupancy, 2);
      chk("skid_ready", in_ready, 0);
      step();
      step();
      chk("skid_hold", out_data, 64'hA);
      out_ready = 1'b1;
      step();
      chk("skid_ready_back", in_ready, 1);
      chk("skid_second", out_data, 64'hB);
      step();
      in_valid = 1'b0;
      chk("skid_third", out_data, 64'hC);
      step();
      chk("skid_sb_empty", sb.size(), 0);

      // ---------------- flush while FULL ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 10'h3FF;
      in_data   = 64'hB;
      step();
      in_data   = 64'hC;
      step();
      in_valid  = 1'b0;
      chk("fl_pre_occ", occupancy, 2);
      chk("fl_pre_ctrl", out_ctrl, 10'h3FF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", out_ctrl, 0);
      chk("fl_ready", in_ready, 1);
      chk("fl_occ", occupancy, 0);
      chk("fl_data_kept", out_data, 64'hB);

      // ---------------- flush with incoming beat ----------------
      in_valid = 1'b1;
      in_data  = 64'hDEAD;
      in_ctrl  = 10'h155;
      flush    = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("dead_valid", out_valid, 0);
         chk("dead_data", (out_data == 64'hDEAD), 0);
         step();
      end

      // ---------------- flush together with a drain ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h55; in_ctrl = 10'h055;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b1;
      chk("fd_head", out_data, 64'h55);
      step();
      flush = 1'b0;
      chk("fd_occ", occupancy, 0);
      chk("fd_valid", out_valid, 0);

      // ---------------- asynchronous reset while FULL ----------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'h11; in_ctrl = 10'h011;
      step();
      in_data   = 64'h22; in_ctrl = 10'h022;
      step();
      in_valid  = 1'b0;
      chk("ar_pre_occ", occupancy, 2);
      #1 rst = 1'b0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_ctrl", out_ctrl, 0);
      chk("ar_data", out_data, 0);
      chk("ar_occ", occupancy, 0);
      chk("ar_ready", in_ready, 1);
      #1 rst = 1'b1;
      sb.delete();
      @(negedge clk);

      // ---------------- random back-pressure ----------------
      n_in = 0;
      cyc  = 0;
      while (n_in < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = $urandom_range(0, 1) != 0;
         in_data   = {$urandom, $urandom};
         in_ctrl   = CW'($urandom);
         if (in_valid && in_ready) n_in++;
         cyc++;
         step();
      end
      chk("rand_beats", (n_in >= 10000), 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 10) begin
         cyc++;
         step();
      end
      chk("rand_sb_empty", sb.size(), 0);
      chk("rand_occ", occupancy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_pipe_stage_hs
`default_nettype wire
